// File: rtl/imm_gen_pipe_if.sv
// Bundle of the instruction-in / immediate-out stream for imm_gen_pipe.
// Both sides use valid/ready: a beat moves on a rising edge where valid && ready; valid may not depend on ready.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [24:0]     in_inst;
  logic [2:0]      in_type;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, in_type, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_type, in_pc, flush, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator: S1 holds the raw instruction and decodes,
// S2 holds the immediate, branch/jump target and illegal flag.
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter bit TARGET_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    TYPE_R   = 3'd0,
    TYPE_I   = 3'd1,
    TYPE_S   = 3'd2,
    TYPE_B   = 3'd3,
    TYPE_U   = 3'd4,
    TYPE_J   = 3'd5,
    TYPE_Z   = 3'd6,
    TYPE_RSV = 3'd7
  } imm_type_e;

  logic            s1_valid;
  logic [24:0]     s1_inst;
  imm_type_e       s1_type;
  logic [XLEN-1:0] s1_pc;

  logic            s2_valid;
  logic [XLEN-1:0] s2_imm;
  logic [XLEN-1:0] s2_target;
  logic            s2_illegal;

  logic            s2_load;
  logic            accept;
  logic signed [31:0] imm32;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] target;
  logic            illegal;

  // s1_inst[k] is instruction bit k+7; the opcode never enters the block.
  always_comb begin
    imm32 = '0;
    case (s1_type)
      TYPE_I:  imm32 = {{20{s1_inst[24]}}, s1_inst[24:13]};
      TYPE_S:  imm32 = {{20{s1_inst[24]}}, s1_inst[24:18], s1_inst[4:0]};
      TYPE_B:  imm32 = {{19{s1_inst[24]}}, s1_inst[24], s1_inst[0],
                        s1_inst[23:18], s1_inst[4:1], 1'b0};
      TYPE_U:  imm32 = {s1_inst[24:5], 12'b0};
      TYPE_J:  imm32 = {{11{s1_inst[24]}}, s1_inst[24], s1_inst[12:5],
                        s1_inst[13], s1_inst[23:14], 1'b0};
      TYPE_Z:  imm32 = {27'b0, s1_inst[12:8]};
      default: imm32 = '0;
    endcase
  end

  // Sign-extending cast widens every 32-bit form to XLEN; Z has bit 31 clear.
  assign imm     = XLEN'(imm32);
  assign illegal = (s1_type == TYPE_RSV);

  generate
    if (TARGET_EN) begin : g_target
      assign target = s1_pc + imm;
    end else begin : g_no_target
      assign target = '0;
    end
  endgenerate

  assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready = !bus.flush && (!s1_valid || s2_load);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        s2_valid <= 1'b1;
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Payload registers only follow the valid bits; their contents are ignored while invalid.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_inst <= bus.in_inst;
      s1_type <= imm_type_e'(bus.in_type);
      s1_pc   <= bus.in_pc;
    end
    if (s2_load) begin
      s2_imm     <= imm;
      s2_target  <= target;
      s2_illegal <= illegal;
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.out_imm     = s2_imm;
  assign bus.out_target  = s2_target;
  assign bus.out_illegal = s2_illegal;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter TARGET_EN, default 1; 1 computes out_target = pc + imm, 0 ties out_target to 0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  upstream offers an instruction.
REQ-006 in_ready  output  1  block accepts the offer this cycle.
REQ-007 in_inst  input  25  instruction bits [31:7], opcode excluded.
REQ-008 in_type  input  3  immediate type: R=0, I=1, S=2, B=3, U=4, J=5, Z=6 (CSR zimm), 7 reserved.
REQ-009 in_pc  input  XLEN  PC of the offered instruction.
REQ-010 flush  input  1  discard all in-flight entries.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream consumes the result.
REQ-013 out_imm  output  XLEN  decoded immediate.
REQ-014 out_target  output  XLEN  pc + out_imm.
REQ-015 out_illegal  output  1  entry carried type 7.

Function
REQ-016 Two register stages: S1 latches inst, type and pc and decodes the immediate; S2 latches imm, illegal and target.
REQ-017 Transfer rule: a stage loads when its predecessor is valid and the stage is empty or being drained in the same cycle.
REQ-018 Input accept: in_valid && in_ready; in_ready = !flush && (!S1.valid || S1 advances this cycle).
REQ-019 Output consume: out_valid && out_ready; out_valid = S2.valid; out_* are driven directly from S2 registers.
REQ-020 Latency: a result is valid 2 cycles after acceptance when no stall occurs; throughput is 1 per cycle when out_ready is held high.
REQ-021 Immediate extraction, bit positions relative to the full instruction:
  - I: sext(inst[31:20])
  - S: sext({inst[31:25], inst[11:7]})
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0})
  - U: sext({inst[31:12], 12'b0})
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0})
  - Z: zext(inst[19:15])
REQ-022 Sign-extension of every signed type uses inst[31] up to XLEN; for XLEN=64, U is sign-extended from bit 31.
REQ-023 R type: imm = 0 and target = pc.
REQ-024 Type 7: imm = 0, target = pc, out_illegal = 1; the entry flows through the pipeline normally.
REQ-025 Target: pc + imm modulo 2^XLEN, with no overflow flag (wrap-around is silent).
REQ-026 Stall: with out_ready low and both stages full, in_ready = 0; S1 and S2 hold their contents unchanged.
REQ-027 Flush: S1.valid and S2.valid clear at the next edge; any offer in the flush cycle is not accepted; out_valid = 0 the cycle after.
REQ-028 Flush and consume in the same cycle: the consumed result counts as delivered, and nothing else survives.
REQ-029 Data registers need no reset; only valid bits are reset.

Reset
REQ-030 While rst is high at an edge, S1.valid and S2.valid = 0, giving out_valid = 0 and in_ready = 1 from the following cycle.
REQ-031 rst has priority over flush, accept and consume; in-flight entries are dropped with no output.
REQ-032 out_imm, out_target and out_illegal are don't-care while out_valid = 0.

Verification
REQ-033 J type: inst 0x0080006F, pc 0x100, out_ready = 1 -> 2 cycles later out_valid = 1, imm = 0x8, target = 0x108.
REQ-034 B type: inst 0xFE000EE3, pc 0x0 -> imm = 0xFFFFFFFC, target = 0xFFFFFFFC (wrap).
REQ-035 Z and illegal types: type Z with inst[19:15] = 0x1F -> imm = 0x1F, illegal = 0; type 7 -> imm = 0, target = pc, illegal = 1.
REQ-036 Stall: 3 back-to-back offers with out_ready = 0 -> third stalls (in_ready = 0); raise out_ready -> all 3 delivered in order, once each.
REQ-037 Flush and reset mid-stream:
  - flush with both stages full and an offer pending -> no output next cycle and offer not taken.
  - rst in the same case -> identical result.
REQ-038 XLEN = 64: U type inst[31:12] = 0x80000 -> imm = 0xFFFFFFFF80000000.
